// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader.
// Latency: none (package only). Backpressure: n/a.
package program_loader_pkg;

   localparam int ADDR_W_DEF     = 16;
   localparam int DATA_W_DEF     = 16;
   localparam int CNT_W_DEF      = 16;
   localparam int BYTES_PER_WORD = 2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LO    = 3'd1,
      HI    = 3'd2,
      WRITE = 3'd3,
      CSUM  = 3'd4,
      DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/loader_word_pack.sv
// Packs accepted stream bytes into a {hi, lo} word; keeps a running XOR under LOADER_CHECKSUM_EN.
// Latency: byte visible on o_word the cycle after i_take. Backpressure: none, caller gates i_take.
module loader_word_pack
   import program_loader_pkg::*;
(
   input  logic                          i_clk,
   input  logic                          i_reset_n,
   input  logic                          i_clr,
   input  logic                          i_take,
   input  logic                          i_sel_hi,
   input  logic [7:0]                    i_byte,
   output logic [8*BYTES_PER_WORD-1:0]   o_word
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic [7:0]                    o_xor
`endif
);

   logic [7:0] r_lo;
   logic [7:0] r_hi;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_lo <= 8'h00;
         r_hi <= 8'h00;
      end else if (i_clr) begin
         r_lo <= 8'h00;
         r_hi <= 8'h00;
      end else if (i_take) begin
         if (i_sel_hi) r_hi <= i_byte;
         else          r_lo <= i_byte;
      end
   end

   assign o_word = {r_hi, r_lo};

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] r_xor;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)  r_xor <= 8'h00;
      else if (i_clr)  r_xor <= 8'h00;
      else if (i_take) r_xor <= r_xor ^ i_byte;
   end

   assign o_xor = r_xor;
`endif

endmodule

// File: rtl/program_loader.sv
// Streams bytes into program memory as 16-bit words, holding the cores until the load completes.
// Latency: write 1 cycle after the hi byte, done 1 cycle after the last write (3 cycles/word min).
// Backpressure: byte_ready registered, high only while a byte is wanted; LOADER_CHECKSUM_EN adds a trailing XOR byte.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [CNT_W-1:0]  i_word_count,
   input  logic [7:0]        i_byte_in,
   input  logic              i_byte_valid,
   output logic              o_byte_ready,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic              o_core_hold,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_error
);

   state_t            r_state;
   logic              r_byte_ready;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_addr;
   logic [CNT_W-1:0]  r_remaining;
   logic              r_core_hold;
   logic              r_busy;
   logic              r_done;
   logic              r_error;

   logic              w_xfer;
   logic              w_start_ok;
   logic              w_take;
   logic [DATA_W-1:0] w_word;

   assign w_xfer     = i_byte_valid & r_byte_ready;
   assign w_start_ok = i_start & (r_state == IDLE);
   assign w_take     = w_xfer & ((r_state == LO) | (r_state == HI));

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] w_xor;
`endif

   loader_word_pack u_pack (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_clr     (w_start_ok),
      .i_take    (w_take),
      .i_sel_hi  (r_state == HI),
      .i_byte    (i_byte_in),
      .o_word    (w_word)
`ifdef LOADER_CHECKSUM_EN
      ,
      .o_xor     (w_xor)
`endif
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state      <= IDLE;
         r_byte_ready <= 1'b0;
         r_mem_we     <= 1'b0;
         r_addr       <= '0;
         r_remaining  <= '0;
         r_core_hold  <= 1'b1;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_mem_we <= 1'b0;
         r_done   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_addr      <= i_base_addr;
                  r_remaining <= i_word_count;
                  r_error     <= 1'b0;
                  r_core_hold <= 1'b1;
                  r_busy      <= 1'b1;
                  if (i_word_count == '0) begin
`ifdef LOADER_CHECKSUM_EN
                     r_state      <= CSUM;
                     r_byte_ready <= 1'b1;
`else
                     r_state <= DONE;
                     r_done  <= 1'b1;
`endif
                  end else begin
                     r_state      <= LO;
                     r_byte_ready <= 1'b1;
                  end
               end
            end
            LO: begin
               if (w_xfer) r_state <= HI;
            end
            HI: begin
               if (w_xfer) begin
                  r_state      <= WRITE;
                  r_byte_ready <= 1'b0;
                  r_mem_we     <= 1'b1;
               end
            end
            WRITE: begin
               // Wrapping past the top of memory corrupts the image layout, so flag it.
               r_addr      <= r_addr + ADDR_W'(1);
               r_remaining <= r_remaining - CNT_W'(1);
               if (&r_addr) r_error <= 1'b1;
               if (r_remaining == CNT_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                  r_state      <= CSUM;
                  r_byte_ready <= 1'b1;
`else
                  r_state <= DONE;
                  r_done  <= 1'b1;
`endif
               end else begin
                  r_state      <= LO;
                  r_byte_ready <= 1'b1;
               end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
               if (w_xfer) begin
                  if (i_byte_in != w_xor) r_error <= 1'b1;
                  r_byte_ready <= 1'b0;
                  r_state      <= DONE;
                  r_done       <= 1'b1;
               end
            end
`endif
            DONE: begin
               if (!r_error) r_core_hold <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_state      <= IDLE;
               r_byte_ready <= 1'b0;
               r_busy       <= 1'b0;
            end
         endcase
      end
   end

   assign o_byte_ready = r_byte_ready;
   assign o_mem_we     = r_mem_we;
   assign o_mem_addr   = r_addr;
   assign o_mem_wdata  = w_word;
   assign o_core_hold  = r_core_hold;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_error      = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; covers the checksum byte when LOADER_CHECKSUM_EN is defined.
module tb_program_loader;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] d;
      logic [31:0] c;
   } wr_t;

   typedef logic [7:0] byte_q_t[$];

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [15:0] base_addr;
   logic [15:0] word_count;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        core_hold;
   logic        busy;
   logic        done;
   logic        error;

   int      n_checks = 0;
   int      n_fail   = 0;
   int      cyc      = 0;
   int      rdy_cnt  = 0;
   wr_t     wr_q[$];
   wr_t     mon_e;
   byte_q_t seq;

   program_loader dut (
      .i_clk        (clk),
      .i_reset_n    (reset_n),
      .i_start      (start),
      .i_base_addr  (base_addr),
      .i_word_count (word_count),
      .i_byte_in    (byte_in),
      .i_byte_valid (byte_valid),
      .o_byte_ready (byte_ready),
      .o_mem_we     (mem_we),
      .o_mem_addr   (mem_addr),
      .o_mem_wdata  (mem_wdata),
      .o_core_hold  (core_hold),
      .o_busy       (busy),
      .o_done       (done),
      .o_error      (error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mem_we) begin
         mon_e.a = mem_addr;
         mon_e.d = mem_wdata;
         mon_e.c = cyc;
         wr_q.push_back(mon_e);
      end
      if (byte_ready) rdy_cnt = rdy_cnt + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_wr(input int idx, input logic [15:0] ea, input logic [15:0] ed);
      if (idx < wr_q.size()) begin
         check_val("wr_addr", wr_q[idx].a, ea);
         check_val("wr_data", wr_q[idx].d, ed);
      end else begin
         check_val("wr_present", wr_q.size(), idx + 1);
      end
   endtask

   // Called at a negedge; the transfer happens at the following posedge.
   task automatic send_byte(input logic [7:0] b, input bit gap);
      int n = 0;
      if (gap) begin
         byte_valid = 1'b0;
         @(negedge clk);
      end
      byte_in    = b;
      byte_valid = 1'b1;
      while (!byte_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!byte_ready) check_val("byte_ready_seen", byte_ready, 1);
      @(negedge clk);
   endtask

   task automatic send_seq(input bit gaps);
      logic [7:0] x = 8'h00;
      foreach (seq[i]) begin
         send_byte(seq[i], gaps && i > 0);
         x = x ^ seq[i];
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(x, gaps);
`endif
      byte_valid = 1'b0;
   endtask

   task automatic do_start(input logic [15:0] b, input logic [15:0] n);
      start      = 1'b1;
      base_addr  = b;
      word_count = n;
      @(negedge clk);
      start      = 1'b0;
      base_addr  = 16'hDEAD;
      word_count = 16'h7777;
   endtask

   task automatic wait_done(output int dc);
      int n = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_val("done_seen", done, 1);
      dc = cyc;
   endtask

   task automatic basic_load(input bit gaps, input string tag);
      int w0;
      int dc;
      w0  = wr_q.size();
      seq = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
      do_start(16'h0006, 16'd3);
      check_val({tag, "_busy"}, busy, 1);
      check_val({tag, "_hold_loading"}, core_hold, 1);
      send_seq(gaps);
      wait_done(dc);
      check_val({tag, "_wr_cnt"}, wr_q.size() - w0, 3);
      check_wr(w0,     16'h0006, 16'h1234);
      check_wr(w0 + 1, 16'h0007, 16'h5678);
      check_wr(w0 + 2, 16'h0008, 16'h9ABC);
      if (wr_q.size() >= w0 + 3) begin
`ifdef LOADER_CHECKSUM_EN
         if (!gaps) check_val({tag, "_done_lat"}, dc - wr_q[w0 + 2].c, 2);
`else
         check_val({tag, "_done_lat"}, dc - wr_q[w0 + 2].c, 1);
`endif
         if (!gaps) check_val({tag, "_word_period"}, wr_q[w0 + 1].c - wr_q[w0].c, 3);
      end
      check_val({tag, "_error"}, error, 0);
      @(negedge clk);
      check_val({tag, "_hold_released"}, core_hold, 0);
      check_val({tag, "_busy_end"}, busy, 0);
      check_val({tag, "_final_addr"}, mem_addr, 16'h0009);
   endtask

   initial begin
      int w0;
      int r0;
      int dc;
      reset_n    = 1'b0;
      start      = 1'b0;
      base_addr  = 16'h0;
      word_count = 16'h0;
      byte_in    = 8'h0;
      byte_valid = 1'b0;
      repeat (2) @(negedge clk);

      check_val("rst_byte_ready", byte_ready, 0);
      check_val("rst_mem_we",     mem_we, 0);
      check_val("rst_mem_addr",   mem_addr, 0);
      check_val("rst_mem_wdata",  mem_wdata, 0);
      check_val("rst_core_hold",  core_hold, 1);
      check_val("rst_busy",       busy, 0);
      check_val("rst_done",       done, 0);
      check_val("rst_error",      error, 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      check_val("idle_hold_after_reset", core_hold, 1);

      basic_load(1'b0, "cont");
      basic_load(1'b1, "gaps");

      // Zero-length load.
      w0 = wr_q.size();
      r0 = rdy_cnt;
      do_start(16'h0040, 16'd0);
`ifdef LOADER_CHECKSUM_EN
      send_byte(8'h00, 1'b0);
      byte_valid = 1'b0;
`endif
      wait_done(dc);
      check_val("zero_wr_cnt", wr_q.size() - w0, 0);
`ifndef LOADER_CHECKSUM_EN
      check_val("zero_ready_never", rdy_cnt - r0, 0);
`endif
      @(negedge clk);
      check_val("zero_hold", core_hold, 0);
      check_val("zero_error", error, 0);

      // Address wrap.
      w0  = wr_q.size();
      seq = '{8'h01, 8'h00, 8'h02, 8'h00};
      do_start(16'hFFFF, 16'd2);
      send_seq(1'b0);
      wait_done(dc);
      check_val("wrap_wr_cnt", wr_q.size() - w0, 2);
      check_wr(w0,     16'hFFFF, 16'h0001);
      check_wr(w0 + 1, 16'h0000, 16'h0002);
      check_val("wrap_error", error, 1);
      @(negedge clk);
      check_val("wrap_hold", core_hold, 1);
      check_val("wrap_error_sticky", error, 1);

      // Start pulse while in HI must be ignored.
      w0 = wr_q.size();
      do_start(16'h0010, 16'd2);
      check_val("restart_clears_error", error, 0);
      send_byte(8'hAA, 1'b0);
      start      = 1'b1;
      base_addr  = 16'h0100;
      word_count = 16'd5;
      send_byte(8'hBB, 1'b0);
      start = 1'b0;
      send_byte(8'hCC, 1'b0);
      send_byte(8'hDD, 1'b0);
`ifdef LOADER_CHECKSUM_EN
      send_byte(8'h00, 1'b0);
`endif
      byte_valid = 1'b0;
      wait_done(dc);
      check_val("busy_start_wr_cnt", wr_q.size() - w0, 2);
      check_wr(w0,     16'h0010, 16'hBBAA);
      check_wr(w0 + 1, 16'h0011, 16'hDDCC);
      @(negedge clk);
      check_val("busy_start_final_addr", mem_addr, 16'h0012);
      check_val("busy_start_hold", core_hold, 0);

      // Reset in the middle of a load.
      w0 = wr_q.size();
      do_start(16'h0020, 16'd4);
      send_byte(8'h34, 1'b0);
      send_byte(8'h12, 1'b0);
      send_byte(8'h56, 1'b0);
      byte_in = 8'h78;
      #2 reset_n = 1'b0;
      #1;
      check_val("mid_rst_byte_ready", byte_ready, 0);
      check_val("mid_rst_mem_we",     mem_we, 0);
      check_val("mid_rst_mem_addr",   mem_addr, 0);
      check_val("mid_rst_mem_wdata",  mem_wdata, 0);
      check_val("mid_rst_core_hold",  core_hold, 1);
      check_val("mid_rst_busy",       busy, 0);
      check_val("mid_rst_done",       done, 0);
      check_val("mid_rst_error",      error, 0);
      repeat (3) @(negedge clk);
      byte_valid = 1'b0;
      reset_n    = 1'b1;
      repeat (4) @(negedge clk);
      check_val("mid_rst_wr_cnt", wr_q.size() - w0, 1);
      check_wr(w0, 16'h0020, 16'h1234);
      check_val("mid_rst_idle_busy", busy, 0);
      check_val("mid_rst_idle_hold", core_hold, 1);

`ifdef LOADER_CHECKSUM_EN
      w0 = wr_q.size();
      do_start(16'h0030, 16'd1);
      send_byte(8'h34, 1'b0);
      send_byte(8'h12, 1'b0);
      send_byte(8'h26, 1'b0);
      byte_valid = 1'b0;
      wait_done(dc);
      check_wr(w0, 16'h0030, 16'h1234);
      check_val("csum_ok_error", error, 0);
      @(negedge clk);
      check_val("csum_ok_hold", core_hold, 0);

      do_start(16'h0030, 16'd1);
      send_byte(8'h34, 1'b0);
      send_byte(8'h12, 1'b0);
      send_byte(8'h27, 1'b0);
      byte_valid = 1'b0;
      wait_done(dc);
      check_val("csum_bad_error", error, 1);
      @(negedge clk);
      check_val("csum_bad_hold", core_hold, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
